// File: rtl/mul_booth_unit.sv
// Iterative radix-8 Booth multiplier for MUL/MULH/MULHSU/MULHU, tagged with ROB index and rd.
// Latency ITER+1 cycles (12 at XLEN=32); zero operand or illegal funct3 completes in 1 cycle.
// Result is held in DONE until o_ready; i_ready only in IDLE or when the held result drains.
module mul_booth_unit #(
  parameter int XLEN      = 32,
  parameter int ROB_IDX_W = 4,
  parameter int RD_W      = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [2:0]           i_funct3,
  input  logic [XLEN-1:0]      i_rs1,
  input  logic [XLEN-1:0]      i_rs2,
  input  logic [ROB_IDX_W-1:0] i_rob_idx,
  input  logic [RD_W-1:0]      i_rd,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [XLEN-1:0]      o_data,
  output logic [ROB_IDX_W-1:0] o_rob_idx,
  output logic [RD_W-1:0]      o_rd,
  output logic                 idle
);

  // Booth steps: ceil((XLEN+1)/3); the multiplier register holds 3*ITER bits.
  localparam int ITER = (XLEN + 3) / 3;
  localparam int MW   = 3 * ITER;
  // Accumulator holds up to |acc + 4M| < 5*2^XLEN without overflow.
  localparam int AW   = XLEN + 4;
  localparam int PW   = AW + MW;
  localparam int CW   = $clog2(ITER);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CW-1:0]          r_cnt;
  logic [AW-1:0]          r_acc;
  logic [MW-1:0]          r_mlr;
  logic                   r_prev;
  logic [AW-1:0]          r_m;
  logic [AW-1:0]          r_m3;
  logic [2:0]             r_funct3;
  logic [ROB_IDX_W-1:0]   r_rob_idx;
  logic [RD_W-1:0]        r_rd;
  logic [XLEN-1:0]        r_data;

  logic                   w_issue;
  logic                   w_fast;
  logic                   w_last;
  logic                   w_s1;
  logic                   w_s2;
  logic [XLEN:0]          w_rs1_ext;
  logic [XLEN:0]          w_rs2_ext;
  logic [AW-1:0]          w_m_init;
  logic [AW-1:0]          w_m3_init;
  logic [MW-1:0]          w_mlr_init;
  logic [3:0]             w_sel;
  logic [AW-1:0]          w_mag;
  logic                   w_neg;
  logic [AW-1:0]          w_sum;
  logic [AW-1:0]          w_acc_nxt;
  logic [MW-1:0]          w_mlr_nxt;
  logic [PW-1:0]          w_prod;
  logic [XLEN-1:0]        w_res;
  logic                   w_unused;

  assign w_issue = i_valid && i_ready && !flush;
  // Either operand zero gives a zero product; funct3 1xx is not a multiply.
  assign w_fast  = (i_rs1 == '0) || (i_rs2 == '0) || i_funct3[2];
  assign w_last  = (r_cnt == CW'(ITER - 1));

  // rs1 signed unless MULHU; rs2 signed only for MUL/MULH.
  assign w_s1       = (i_funct3[1:0] != 2'b11);
  assign w_s2       = (i_funct3[1] == 1'b0);
  assign w_rs1_ext  = {w_s1 & i_rs1[XLEN-1], i_rs1};
  assign w_rs2_ext  = {w_s2 & i_rs2[XLEN-1], i_rs2};
  assign w_m_init   = AW'($signed(w_rs1_ext));
  assign w_m3_init  = w_m_init + {w_m_init[AW-2:0], 1'b0};
  assign w_mlr_init = MW'($signed(w_rs2_ext));

  // Radix-8 digit decode of {b[3i+2:3i], b[3i-1]} into magnitude and sign.
  assign w_sel = {r_mlr[2:0], r_prev};
  always_comb begin
    w_mag = '0;
    w_neg = 1'b0;
    case (w_sel)
      4'b0001, 4'b0010: w_mag = r_m;
      4'b0011, 4'b0100: w_mag = {r_m[AW-2:0], 1'b0};
      4'b0101, 4'b0110: w_mag = r_m3;
      4'b0111:          w_mag = {r_m[AW-3:0], 2'b00};
      4'b1000:          begin w_mag = {r_m[AW-3:0], 2'b00}; w_neg = 1'b1; end
      4'b1001, 4'b1010: begin w_mag = r_m3;                 w_neg = 1'b1; end
      4'b1011, 4'b1100: begin w_mag = {r_m[AW-2:0], 1'b0};  w_neg = 1'b1; end
      4'b1101, 4'b1110: begin w_mag = r_m;                  w_neg = 1'b1; end
      default:          begin w_mag = '0;                   w_neg = 1'b0; end
    endcase
  end

  // One step: add the digit multiple, then shift {acc, mlr} right by 3 arithmetically.
  assign w_sum     = w_neg ? (r_acc - w_mag) : (r_acc + w_mag);
  assign w_acc_nxt = $signed(w_sum) >>> 3;
  assign w_mlr_nxt = {w_sum[2:0], r_mlr[MW-1:3]};
  assign w_prod    = {w_acc_nxt, w_mlr_nxt};
  assign w_res     = (r_funct3[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
  assign w_unused  = ^{w_prod[PW-1:2*XLEN], r_funct3[2]};

  // Handshake and status outputs decoded from the registered state.
  always_comb begin
    i_ready = (r_state == IDLE) || ((r_state == DONE) && o_ready);
    o_valid = (r_state == DONE);
    idle    = (r_state == IDLE);
  end

  // Next-state logic; flush overrides every other event.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_issue) w_state_nxt = w_fast ? DONE : CALC;
      CALC:    if (w_last) w_state_nxt = DONE;
      DONE:    if (o_ready) w_state_nxt = w_issue ? (w_fast ? DONE : CALC) : IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (flush) w_state_nxt = IDLE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Operand capture at issue, Booth iteration in CALC, result register on completion.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_mlr     <= '0;
      r_prev    <= 1'b0;
      r_m       <= '0;
      r_m3      <= '0;
      r_funct3  <= '0;
      r_rob_idx <= '0;
      r_rd      <= '0;
      r_data    <= '0;
    end else if (w_issue) begin
      r_funct3  <= i_funct3;
      r_rob_idx <= i_rob_idx;
      r_rd      <= i_rd;
      r_m       <= w_m_init;
      r_m3      <= w_m3_init;
      r_acc     <= '0;
      r_mlr     <= w_mlr_init;
      r_prev    <= 1'b0;
      r_cnt     <= '0;
      if (w_fast) r_data <= '0;
    end else if ((r_state == CALC) && !flush) begin
      r_acc  <= w_acc_nxt;
      r_mlr  <= w_mlr_nxt;
      r_prev <= r_mlr[2];
      r_cnt  <= r_cnt + 1'b1;
      if (w_last) r_data <= w_res;
    end
  end

  assign o_data    = r_data;
  assign o_rob_idx = r_rob_idx;
  assign o_rd      = r_rd;

endmodule
